// File: rtl/lstm_seq_driver.sv
// lstm_seq_driver: sequences an lstm_unit_v2 over timesteps, owning the recurrent a/c state memories
module lstm_seq_driver #(
  parameter int total_bit = 10,
  parameter int X_LEN = 8,
  parameter int H_LEN = 301,
  parameter int STEP_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic                 x_valid,
  input  logic [total_bit-1:0] x_data,
  output logic                 x_ready,
  output logic                 unit_reset,
  output logic                 unit_load,
  output logic [total_bit-1:0] unit_xt,
  output logic [total_bit-1:0] unit_a_prev,
  output logic [total_bit-1:0] unit_c_prev,
  input  logic                 unit_done,
  input  logic                 unit_output_done,
  input  logic [total_bit-1:0] unit_a_next,
  input  logic [total_bit-1:0] unit_c_next,
  output logic                 h_valid,
  output logic [total_bit-1:0] h_data,
  output logic [8:0]           h_idx,
  output logic                 h_last,
  output logic                 busy,
  output logic                 step_done,
  output logic                 seq_done
);
  localparam int XW = $clog2(X_LEN);
  localparam logic [8:0] HL = 9'(H_LEN);
  localparam logic [8:0] XL9 = 9'(X_LEN);
  localparam logic [3:0] XL = 4'(X_LEN);
  typedef enum logic [2:0] {IDLE, FETCH_X, STREAM, WAIT_DONE, CAPTURE, FLUSH, CLEAR} state_t;
  state_t r_state;
  logic r_first;
  logic [8:0] r_idx;
  logic [3:0] r_n;
  logic [STEP_W-1:0] r_step, r_num;
  logic [total_bit-1:0] r_xbuf [0:X_LEN-1];
  logic [total_bit-1:0] r_amem [0:H_LEN-1];
  logic [total_bit-1:0] r_cmem [0:H_LEN-1];
  logic [8:0] w_nidx, w_mi;
  logic [XW-1:0] w_xi;
  logic [total_bit-1:0] w_xt, w_ap, w_cp;
  logic w_acc, w_last_step;
  // operands for the element presented after the coming edge
  always_comb begin
    w_nidx = (r_state == STREAM) ? r_idx + 9'd1 : 9'd1;
    w_mi = w_nidx - 9'd1;
    w_xi = w_mi[XW-1:0];
    w_xt = (w_nidx <= XL9) ? r_xbuf[w_xi] : '0;
    w_ap = r_first ? '0 : r_amem[w_mi];
    w_cp = r_first ? '0 : r_cmem[w_mi];
    w_acc = (r_state == FETCH_X) && x_valid && x_ready;
    w_last_step = (r_step + STEP_W'(1)) == r_num;
  end
  always_ff @(posedge clk) begin
    if (!reset && w_acc) r_xbuf[XW'(r_n - 4'd1)] <= x_data;
    if (!reset && r_state == CAPTURE) begin
      r_amem[r_idx - 9'd1] <= unit_a_next;
      r_cmem[r_idx - 9'd1] <= unit_c_next;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_first <= 1'b1;
      r_idx <= '0;
      r_n <= 4'd1;
      r_step <= '0;
      r_num <= '0;
      x_ready <= 1'b0;
      unit_reset <= 1'b1;
      unit_load <= 1'b0;
      unit_xt <= '0;
      unit_a_prev <= '0;
      unit_c_prev <= '0;
      h_valid <= 1'b0;
      h_data <= '0;
      h_idx <= '0;
      h_last <= 1'b0;
      busy <= 1'b0;
      step_done <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      unit_reset <= 1'b0;
      step_done <= 1'b0;
      seq_done <= 1'b0;
      h_valid <= 1'b0;
      h_last <= 1'b0;
      unit_xt <= '0;
      unit_a_prev <= '0;
      unit_c_prev <= '0;
      case (r_state)
        IDLE: if (start) begin
          if (num_steps == '0) seq_done <= 1'b1;
          else begin
            r_state <= FETCH_X;
            r_first <= 1'b1;
            r_step <= '0;
            r_num <= num_steps;
            r_n <= 4'd1;
            x_ready <= 1'b1;
            busy <= 1'b1;
          end
        end
        FETCH_X: if (w_acc) begin
          r_n <= r_n + 4'd1;
          if (r_n == XL) begin
            r_state <= STREAM;
            r_idx <= 9'd1;
            x_ready <= 1'b0;
            unit_load <= 1'b1;
            unit_xt <= w_xt;
            unit_a_prev <= w_ap;
            unit_c_prev <= w_cp;
          end
        end
        STREAM: if (r_idx == HL) r_state <= WAIT_DONE;
        else begin
          r_idx <= r_idx + 9'd1;
          unit_xt <= w_xt;
          unit_a_prev <= w_ap;
          unit_c_prev <= w_cp;
        end
        WAIT_DONE: if (unit_done) begin
          r_state <= CAPTURE;
          r_idx <= 9'd1;
        end
        CAPTURE: begin
          h_valid <= 1'b1;
          h_data <= unit_a_next;
          h_idx <= r_idx;
          h_last <= r_idx == HL;
          if (r_idx == HL) r_state <= FLUSH;
          else r_idx <= r_idx + 9'd1;
        end
        FLUSH: if (unit_output_done) begin
          r_state <= CLEAR;
          unit_load <= 1'b0;
          unit_reset <= 1'b1;
          step_done <= 1'b1;
          seq_done <= w_last_step;
        end
        CLEAR: begin
          r_first <= 1'b0;
          r_step <= r_step + STEP_W'(1);
          if (w_last_step) begin
            r_state <= IDLE;
            busy <= 1'b0;
          end else begin
            r_state <= FETCH_X;
            r_n <= 4'd1;
            x_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_seq_driver.sv
// tb_lstm_seq_driver: directed bench with a behavioural serial LSTM unit model
module tb_lstm_seq_driver;
  localparam int H = 301;
  logic clk = 0, reset = 1, start = 0, x_valid = 0;
  logic [15:0] num_steps = 0;
  logic [9:0] x_data = 0;
  logic x_ready, unit_reset, unit_load, h_valid, h_last, busy, step_done, seq_done;
  logic [9:0] unit_xt, unit_a_prev, unit_c_prev, h_data;
  logic [8:0] h_idx;
  logic unit_done = 0, unit_output_done = 0;
  logic [9:0] unit_a_next = 0, unit_c_next = 0;
  int tests = 0, fails = 0;

  lstm_seq_driver dut (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .unit_reset(unit_reset), .unit_load(unit_load), .unit_xt(unit_xt),
    .unit_a_prev(unit_a_prev), .unit_c_prev(unit_c_prev),
    .unit_done(unit_done), .unit_output_done(unit_output_done),
    .unit_a_next(unit_a_next), .unit_c_next(unit_c_next),
    .h_valid(h_valid), .h_data(h_data), .h_idx(h_idx), .h_last(h_last),
    .busy(busy), .step_done(step_done), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  // unit model: mc counts loaded edges since the last unit_reset; a_next[k]=k, c_next[k]=-k
  int mc = 0;
  initial forever begin
    @(negedge clk);
    if (unit_reset) begin
      mc = 0;
      unit_done = 0;
      unit_output_done = 0;
      unit_a_next = 0;
      unit_c_next = 0;
    end else begin
      unit_done = mc >= H;
      unit_output_done = mc >= 2 * H + 1;
      unit_a_next = (mc > H && mc <= 2 * H) ? 10'(mc - H) : 10'd0;
      unit_c_next = (mc > H && mc <= 2 * H) ? 10'(H - mc) : 10'd0;
      if (unit_load) mc++;
    end
  end

  int cyc = 0, li = 0, ld_total, acc_total, sd_total, qd_total, ur_pulses, hl_total, sd_cyc, qd_cyc;
  logic ur_prev = 1, busy_at_qd;
  int hn [0:3];
  int acc8_cyc [0:3];
  int fl_cyc [0:3];
  logic [9:0] rxt [0:3][1:H];
  logic [9:0] rap [0:3][1:H];
  logic [9:0] rcp [0:3][1:H];
  logic [9:0] rhd [0:3][1:H];
  logic [8:0] rhi [0:3][1:H];
  logic rhl [0:3][1:H];

  always @(negedge clk) begin
    int s;
    cyc++;
    s = sd_total > 3 ? 3 : sd_total;
    if (unit_reset) li = 0;
    else if (unit_load) begin
      li++;
      ld_total++;
      if (li == 1) fl_cyc[s] = cyc;
      if (li <= H) begin
        rxt[s][li] = unit_xt;
        rap[s][li] = unit_a_prev;
        rcp[s][li] = unit_c_prev;
      end
    end
    if (x_valid && x_ready) begin
      acc_total++;
      if (acc_total % 8 == 0) acc8_cyc[s] = cyc;
    end
    if (h_valid) begin
      if (hn[s] < H) begin
        rhd[s][hn[s] + 1] = h_data;
        rhi[s][hn[s] + 1] = h_idx;
        rhl[s][hn[s] + 1] = h_last;
      end
      hn[s]++;
      if (h_last) hl_total++;
    end
    if (step_done) begin sd_total++; sd_cyc = cyc; end
    if (seq_done) begin qd_total++; qd_cyc = cyc; busy_at_qd = busy; end
    if (unit_reset && !ur_prev) ur_pulses++;
    ur_prev = unit_reset;
  end

  task clear_stats;
    ld_total = 0; acc_total = 0; sd_total = 0; qd_total = 0; ur_pulses = 0; hl_total = 0;
    sd_cyc = -1; qd_cyc = -2;
    for (int i = 0; i < 4; i++) begin hn[i] = 0; acc8_cyc[i] = -10; fl_cyc[i] = -20; end
  endtask

  task do_start(input int n);
    @(posedge clk); #1;
    start = 1; num_steps = 16'(n);
    @(posedge clk); #1;
    start = 0;
  endtask

  task feed_x(input int base, input int stall);
    int i, t;
    logic r;
    i = 0; t = 0;
    while (i < 8 && t < 2000) begin
      if (stall > 0 && i == 3) begin
        x_valid = 0;
        for (int c = 0; c < stall; c++) begin
          @(posedge clk); #1;
          tests++;
          if (unit_load !== 1'b0) begin fails++; $display("FAIL stall_load cyc=%0d got=%b want=0", c, unit_load); end
        end
        stall = 0;
      end
      x_valid = 1; x_data = 10'(base + i); r = x_ready;
      @(posedge clk); #1;
      if (r) i++;
      t++;
    end
    x_valid = 0;
    tests++;
    if (i != 8) begin fails++; $display("FAIL feed_timeout got=%0d want=8", i); end
  endtask

  task wait_seq(input int target);
    int t;
    for (t = 0; t < 4000 && qd_total < target; t++) @(negedge clk);
    tests++;
    if (qd_total < target) begin fails++; $display("FAIL seq_timeout got=%0d want=%0d", qd_total, target); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task check_operands(input int s, input int xbase, input int ac);
    int bad, bk;
    logic [9:0] ga, wa;
    bad = 0; bk = 0; ga = 0; wa = 0;
    for (int k = 1; k <= H; k++) begin
      logic [9:0] ex, ea, ec;
      ex = k <= 8 ? 10'(xbase + k - 1) : 10'd0;
      ea = ac ? 10'(k) : 10'd0;
      ec = ac ? 10'(-k) : 10'd0;
      if (rxt[s][k] !== ex || rap[s][k] !== ea || rcp[s][k] !== ec) begin
        if (bad == 0) begin bk = k; ga = rxt[s][k] ^ rap[s][k] ^ rcp[s][k]; wa = ex ^ ea ^ ec; end
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL operands step=%0d bad=%0d first_k=%0d got_xor=%h want_xor=%h", s, bad, bk, ga, wa); end
  endtask

  task test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({unit_reset, unit_load, x_ready, busy, step_done, seq_done, h_valid, h_last} !== 8'b1000_0000) begin
      fails++; $display("FAIL reset_ctrl got=%b want=10000000", {unit_reset, unit_load, x_ready, busy, step_done, seq_done, h_valid, h_last});
    end
    tests++;
    if ({unit_xt, unit_a_prev, unit_c_prev, h_data, h_idx} !== 49'd0) begin fails++; $display("FAIL reset_data got=%h want=0", {unit_xt, unit_a_prev, unit_c_prev, h_data, h_idx}); end
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    tests++;
    if (unit_reset !== 1'b0) begin fails++; $display("FAIL unit_reset_release got=%b want=0", unit_reset); end
  endtask

  task test_single_step;
    clear_stats;
    do_start(1);
    feed_x(1, 0);
    wait_seq(1);
    tests++;
    if (ld_total != 604) begin fails++; $display("FAIL load_cycles got=%0d want=604", ld_total); end
    check_operands(0, 1, 0);
    tests++;
    if (ur_pulses != 1) begin fails++; $display("FAIL unit_reset_pulses got=%0d want=1", ur_pulses); end
    tests++;
    if (sd_total != 1 || qd_total != 1 || sd_cyc != qd_cyc) begin
      fails++; $display("FAIL done_pulses step=%0d seq=%0d step_cyc=%0d seq_cyc=%0d", sd_total, qd_total, sd_cyc, qd_cyc);
    end
    tests++;
    if (fl_cyc[0] != acc8_cyc[0] + 1) begin fails++; $display("FAIL stream_start got=%0d want=%0d", fl_cyc[0], acc8_cyc[0] + 1); end
    begin
      int bad;
      bad = 0;
      for (int k = 1; k <= H; k++)
        if (rhd[0][k] !== 10'(k) || rhi[0][k] !== 9'(k) || rhl[0][k] !== (k == H)) bad++;
      tests++;
      if (hn[0] != H || bad != 0 || hl_total != 1) begin
        fails++; $display("FAIL h_stream count=%0d bad=%0d lasts=%0d want=301/0/1", hn[0], bad, hl_total);
      end
    end
    tests++;
    if (busy_at_qd !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL busy_end at_seq=%b after=%b want=1/0", busy_at_qd, busy); end
  endtask

  task test_multi_step;
    clear_stats;
    do_start(3);
    feed_x(100, 0);
    feed_x(200, 20);
    feed_x(300, 0);
    wait_seq(1);
    tests++;
    if (sd_total != 3 || qd_total != 1 || acc_total != 24) begin
      fails++; $display("FAIL multi_counts step=%0d seq=%0d acc=%0d want=3/1/24", sd_total, qd_total, acc_total);
    end
    tests++;
    if (ur_pulses != 3) begin fails++; $display("FAIL multi_unit_reset got=%0d want=3", ur_pulses); end
    check_operands(0, 100, 0);
    check_operands(1, 200, 1);
    check_operands(2, 300, 1);
    tests++;
    if (rcp[1][1] !== 10'h3FF) begin fails++; $display("FAIL c_prev_k1 got=%h want=3ff", rcp[1][1]); end
    tests++;
    if (fl_cyc[1] != acc8_cyc[1] + 1) begin fails++; $display("FAIL stall_stream_start got=%0d want=%0d", fl_cyc[1], acc8_cyc[1] + 1); end
    tests++;
    if (busy_at_qd !== 1'b1 || busy !== 1'b0 || sd_cyc != qd_cyc) begin
      fails++; $display("FAIL multi_busy at_seq=%b after=%b sd_cyc=%0d qd_cyc=%0d", busy_at_qd, busy, sd_cyc, qd_cyc);
    end
  endtask

  task test_reset_mid;
    int t;
    clear_stats;
    do_start(2);
    feed_x(50, 0);
    for (t = 0; t < 2000 && !(h_valid && h_idx == 9'd149); t++) @(negedge clk);
    tests++;
    if (t >= 2000) begin fails++; $display("FAIL mid_wait_timeout got=%0d want=<2000", t); end
    reset = 1;
    @(negedge clk);
    tests++;
    if ({unit_reset, unit_load, x_ready, busy, step_done, seq_done, h_valid, h_last} !== 8'b1000_0000) begin
      fails++; $display("FAIL mid_reset_ctrl got=%b want=10000000", {unit_reset, unit_load, x_ready, busy, step_done, seq_done, h_valid, h_last});
    end
    tests++;
    if (sd_total != 0 || qd_total != 0) begin fails++; $display("FAIL mid_reset_pulses step=%0d seq=%0d want=0/0", sd_total, qd_total); end
    @(posedge clk); #1;
    reset = 0;
    clear_stats;
    do_start(1);
    feed_x(60, 0);
    wait_seq(1);
    check_operands(0, 60, 0);
    tests++;
    if (ld_total != 604) begin fails++; $display("FAIL restart_load got=%0d want=604", ld_total); end
  endtask

  task test_zero_steps;
    clear_stats;
    @(posedge clk); #1;
    start = 1; num_steps = 0;
    @(posedge clk); #1;
    start = 0;
    tests++;
    if (seq_done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL zero_seq_done got=%b busy=%b want=1/0", seq_done, busy); end
    @(posedge clk); #1;
    tests++;
    if (seq_done !== 1'b0) begin fails++; $display("FAIL zero_seq_pulse got=%b want=0", seq_done); end
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (ld_total != 0 || busy !== 1'b0 || x_ready !== 1'b0) begin
      fail_zero: begin fails++; $display("FAIL zero_idle load=%0d busy=%b x_ready=%b want=0/0/0", ld_total, busy, x_ready); end
    end
  endtask

  task test_back_to_back;
    clear_stats;
    do_start(1);
    feed_x(7, 0);
    repeat (50) @(posedge clk);
    #1;
    start = 1; num_steps = 4;
    @(posedge clk); #1;
    start = 0;
    wait_seq(1);
    tests++;
    if (sd_total != 1 || qd_total != 1 || ld_total != 604) begin
      fails++; $display("FAIL busy_start step=%0d seq=%0d load=%0d want=1/1/604", sd_total, qd_total, ld_total);
    end
    do_start(1);
    feed_x(9, 0);
    wait_seq(2);
    tests++;
    if (sd_total != 2 || ld_total != 1208) begin fails++; $display("FAIL b2b_counts step=%0d load=%0d want=2/1208", sd_total, ld_total); end
    check_operands(1, 9, 0);
  endtask

  initial begin
    clear_stats;
    test_reset;
    test_single_step;
    test_multi_step;
    test_reset_mid;
    test_zero_steps;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
